// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//
// Parameterised integer ALU: add, subtract, bitwise logic, shifts and
// rotates on two WIDTH-bit operands. It produces a result and four status
// flags. By default the block is purely combinational. With REGISTERED=1,
// one output register stage is added. That stage is cleared by a
// synchronous active-high reset.
//
// Parameters
//   WIDTH       operand/result width (power of two, >= 2)
//   REGISTERED  0 = combinational outputs, 1 = one registered output stage
//
// Ports
//   clk       in   1      clock (only meaningful when REGISTERED=1)
//   rst       in   1      synchronous active-high reset (REGISTERED=1 only)
//   A         in   WIDTH  operand A, also the shift/rotate source
//   B         in   WIDTH  operand B, low log2(WIDTH) bits give the shift amount
//   opcode    in   4      operation select
//   Result    out  WIDTH  operation result
//   CarryOut  out  1      ADD carry out / SUB borrow
//   Zero      out  1      Result == 0
//   Overflow  out  1      signed overflow for ADD/SUB
//   Negative  out  1      Result MSB
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH      = 4,
  parameter bit REGISTERED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             Negative
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [SHW-1:0]     w_shamt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_sra;
  logic [2*WIDTH-1:0] w_rolWide;
  logic [2*WIDTH-1:0] w_rorWide;

  logic [WIDTH-1:0]   w_result;
  logic               w_carry;
  logic               w_overflow;
  logic               w_zero;
  logic               w_negative;

  // The shift amount wraps modulo WIDTH, so the upper B bits are ignored.
  assign w_shamt = B[SHW-1:0];

  // The extra top bit of the zero-extended difference is set exactly when
  // A < B unsigned. That bit is the borrow.
  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};

  assign w_sra = WIDTH'($signed(A) >>> w_shamt);

  // Rotates shift a doubled copy of A and take one half of it. This
  // avoids a variable-width OR of two opposite shifts.
  assign w_rolWide = {A, A} << w_shamt;
  assign w_rorWide = {A, A} >> w_shamt;

  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (opcode)
      4'h0: begin
        w_result   = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        w_overflow = (A[MSB] == B[MSB]) & (w_sum[MSB] != A[MSB]);
      end
      4'h1: begin
        w_result   = w_diff[WIDTH-1:0];
        w_carry    = w_diff[WIDTH];
        w_overflow = (A[MSB] != B[MSB]) & (w_diff[MSB] != A[MSB]);
      end
      4'h2:    w_result = A & B;
      4'h3:    w_result = A | B;
      4'h4:    w_result = A ^ B;
      4'h5:    w_result = ~A;
      4'h6:    w_result = ~(A & B);
      4'h7:    w_result = A << w_shamt;
      4'h8:    w_result = A >> w_shamt;
      4'h9:    w_result = w_sra;
      4'hA:    w_result = w_rolWide[2*WIDTH-1:WIDTH];
      4'hB:    w_result = w_rorWide[WIDTH-1:0];
      default: w_result = '0;
    endcase
  end

  assign w_zero     = (w_result == '0);
  assign w_negative = w_result[MSB];

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] r_result;
      logic             r_carry;
      logic             r_zero;
      logic             r_overflow;
      logic             r_negative;

      // Reset clears every flag, including Zero. That is a reset value, not
      // a flag derived from the cleared Result.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_result   <= '0;
          r_carry    <= 1'b0;
          r_zero     <= 1'b0;
          r_overflow <= 1'b0;
          r_negative <= 1'b0;
        end else begin
          r_result   <= w_result;
          r_carry    <= w_carry;
          r_zero     <= w_zero;
          r_overflow <= w_overflow;
          r_negative <= w_negative;
        end
      end

      assign Result   = r_result;
      assign CarryOut = r_carry;
      assign Zero     = r_zero;
      assign Overflow = r_overflow;
      assign Negative = r_negative;
    end else begin : g_comb
      // clk and rst have no function in the combinational build.
      logic w_unused;
      assign w_unused = clk ^ rst;

      assign Result   = w_result;
      assign CarryOut = w_carry;
      assign Zero     = w_zero;
      assign Overflow = w_overflow;
      assign Negative = w_negative;
    end
  endgenerate

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic clk;
  logic rst;

  // Combinational WIDTH=4 instance
  logic [3:0] a4, b4, op4;
  logic [3:0] res4;
  logic       c4, z4, v4, n4;

  // Combinational WIDTH=8 instance
  logic [7:0] a8, b8;
  logic [3:0] op8;
  logic [7:0] res8;
  logic       c8, z8, v8, n8;

  // Registered WIDTH=4 instance
  logic [3:0] aR, bR, opR;
  logic [3:0] resR;
  logic       cR, zR, vR, nR;

  int checks;
  int errors;

  alu #(.WIDTH(4), .REGISTERED(1'b0)) u_alu4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .opcode(op4),
    .Result(res4), .CarryOut(c4), .Zero(z4), .Overflow(v4), .Negative(n4)
  );

  alu #(.WIDTH(8), .REGISTERED(1'b0)) u_alu8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .opcode(op8),
    .Result(res8), .CarryOut(c8), .Zero(z8), .Overflow(v8), .Negative(n8)
  );

  alu #(.WIDTH(4), .REGISTERED(1'b1)) u_aluR (
    .clk(clk), .rst(rst), .A(aR), .B(bR), .opcode(opR),
    .Result(resR), .CarryOut(cR), .Zero(zR), .Overflow(vR), .Negative(nR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent reference model: returns {carry, overflow, result[7:0]}.
  // Shifts are modelled one bit at a time.
  function automatic logic [9:0] refAlu(input int w, input int a, input int b, input int op);
    int mask;
    int msb;
    int r;
    int c;
    int v;
    int sh;
    int s;
    int abit;
    int bbit;
    int rbit;
    logic [7:0] r8;
    mask = (1 << w) - 1;
    msb  = w - 1;
    r    = 0;
    c    = 0;
    v    = 0;
    sh   = b % w;
    abit = (a >> msb) & 1;
    bbit = (b >> msb) & 1;
    case (op)
      0: begin
        s = a + b;
        r = s & mask;
        c = (s >> w) & 1;
        rbit = (r >> msb) & 1;
        v = ((abit == bbit) && (rbit != abit)) ? 1 : 0;
      end
      1: begin
        r = (a - b) & mask;
        c = (a < b) ? 1 : 0;
        rbit = (r >> msb) & 1;
        v = ((abit != bbit) && (rbit != abit)) ? 1 : 0;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~a) & mask;
      6: r = (~(a & b)) & mask;
      7, 8, 9, 10, 11: begin
        r = a;
        for (int i = 0; i < sh; i++) begin
          case (op)
            7:  r = (r << 1) & mask;
            8:  r = r >> 1;
            9:  r = (r >> 1) | (((r >> msb) & 1) << msb);
            10: r = ((r << 1) | ((r >> msb) & 1)) & mask;
            default: r = (r >> 1) | ((r & 1) << msb);
          endcase
        end
      end
      default: r = 0;
    endcase
    r8 = r[7:0];
    return {c[0], v[0], r8};
  endfunction

  // Directed shift/rotate vectors, with shamt 1 given both as B=1 and B=5.
  task automatic test_shifts();
    logic [3:0] ops [5];
    logic [7:0] exps [5];
    logic [7:0] got;
    logic [3:0] bs [2];
    ops  = '{4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    exps = '{8'b0010_0000, 8'b0100_0000, 8'b1100_0001, 8'b0011_0000, 8'b1100_0001};
    bs   = '{4'd1, 4'd5};
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 5; i++) begin
        a4 = 4'b1001; b4 = bs[j]; op4 = ops[i];
        #1;
        got = {res4, c4, z4, v4, n4};
        checks++;
        if (got !== exps[i]) begin
          errors++;
          $display("[TB] FAIL shift op=%h B=%0d got=%b expected=%b", ops[i], bs[j], got, exps[i]);
        end
      end
    end
  endtask

  task automatic test_arith();
    logic [3:0] as [4];
    logic [3:0] bs [4];
    logic [3:0] ops [4];
    logic [7:0] exps [4];
    logic [7:0] got;
    as   = '{4'd7, 4'd8, 4'd2, 4'd5};
    bs   = '{4'd2, 4'd8, 4'd9, 4'd5};
    ops  = '{4'h0, 4'h0, 4'h1, 4'h1};
    exps = '{{4'd9, 4'b0011}, {4'd0, 4'b1110}, {4'd9, 4'b1011}, {4'd0, 4'b0100}};
    for (int i = 0; i < 4; i++) begin
      a4 = as[i]; b4 = bs[i]; op4 = ops[i];
      #1;
      got = {res4, c4, z4, v4, n4};
      checks++;
      if (got !== exps[i]) begin
        errors++;
        $display("[TB] FAIL arith op=%h A=%0d B=%0d got=%b expected=%b", ops[i], as[i], bs[i], got, exps[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [3:0] as [4];
    logic [3:0] bs [4];
    logic [3:0] ops [4];
    logic [7:0] exps [4];
    logic [7:0] got;
    as   = '{4'd9, 4'd9, 4'd9, 4'd9};
    bs   = '{4'd5, 4'd0, 4'd6, 4'd6};
    ops  = '{4'h4, 4'h5, 4'h6, 4'h2};
    exps = '{{4'd12, 4'b0001}, {4'd6, 4'b0000}, {4'd15, 4'b0001}, {4'd0, 4'b0100}};
    for (int i = 0; i < 4; i++) begin
      a4 = as[i]; b4 = bs[i]; op4 = ops[i];
      #1;
      got = {res4, c4, z4, v4, n4};
      checks++;
      if (got !== exps[i]) begin
        errors++;
        $display("[TB] FAIL logic op=%h A=%0d B=%0d got=%b expected=%b", ops[i], as[i], bs[i], got, exps[i]);
      end
    end
  endtask

  task automatic test_unused();
    logic [7:0] got;
    for (int op = 12; op < 16; op++) begin
      a4 = 4'hF; b4 = 4'hF; op4 = op[3:0];
      #1;
      got = {res4, c4, z4, v4, n4};
      checks++;
      if (got !== 8'b0000_0100) begin
        errors++;
        $display("[TB] FAIL unused op=%h got=%b expected=%b", op[3:0], got, 8'b0000_0100);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0]  m;
    logic [11:0] got8;
    logic [11:0] exp8;
    logic [7:0]  got4;
    logic [7:0]  exp4;
    int a;
    int b;
    int op;
    for (int i = 0; i < 600; i++) begin
      a  = $urandom_range(0, 15);
      b  = $urandom_range(0, 15);
      op = $urandom_range(0, 15);
      a4 = a[3:0]; b4 = b[3:0]; op4 = op[3:0];
      #1;
      m    = refAlu(4, a, b, op);
      exp4 = {m[3:0], m[9], (m[3:0] == 4'd0), m[8], m[3]};
      got4 = {res4, c4, z4, v4, n4};
      checks++;
      if (got4 !== exp4) begin
        errors++;
        $display("[TB] FAIL random4 op=%h A=%h B=%h got=%b expected=%b", op[3:0], a[3:0], b[3:0], got4, exp4);
      end
    end
    for (int i = 0; i < 600; i++) begin
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      op = $urandom_range(0, 15);
      a8 = a[7:0]; b8 = b[7:0]; op8 = op[3:0];
      #1;
      m    = refAlu(8, a, b, op);
      exp8 = {m[7:0], m[9], (m[7:0] == 8'd0), m[8], m[7]};
      got8 = {res8, c8, z8, v8, n8};
      checks++;
      if (got8 !== exp8) begin
        errors++;
        $display("[TB] FAIL random8 op=%h A=%h B=%h got=%b expected=%b", op[3:0], a[7:0], b[7:0], got8, exp8);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    @(negedge clk);
    rst = 1'b1; aR = 4'd15; bR = 4'd15; opR = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    got = {resR, cR, zR, vR, nR};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_hold got=%b expected=%b", got, 8'h00);
    end
  endtask

  task automatic test_registered();
    logic [7:0] got;
    @(negedge clk);
    rst = 1'b0; aR = 4'd7; bR = 4'd2; opR = 4'h0;
    #1;
    got = {resR, cR, zR, vR, nR};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reg_before_edge got=%b expected=%b", got, 8'h00);
    end
    @(posedge clk);
    #1;
    got = {resR, cR, zR, vR, nR};
    checks++;
    if (got !== {4'd9, 4'b0011}) begin
      errors++;
      $display("[TB] FAIL reg_add got=%b expected=%b", got, {4'd9, 4'b0011});
    end
    // Inputs changed between edges must not disturb the held outputs.
    #2;
    aR = 4'd5; bR = 4'd5; opR = 4'h1;
    #1;
    got = {resR, cR, zR, vR, nR};
    checks++;
    if (got !== {4'd9, 4'b0011}) begin
      errors++;
      $display("[TB] FAIL reg_hold got=%b expected=%b", got, {4'd9, 4'b0011});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    @(posedge clk);
    #1;
    got = {resR, cR, zR, vR, nR};
    checks++;
    if (got !== {4'd0, 4'b0100}) begin
      errors++;
      $display("[TB] FAIL b2b_sub got=%b expected=%b", got, {4'd0, 4'b0100});
    end
    @(negedge clk);
    aR = 4'd9; bR = 4'd5; opR = 4'h4; rst = 1'b1;
    @(posedge clk);
    #1;
    got = {resR, cR, zR, vR, nR};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midstream_reset got=%b expected=%b", got, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0; aR = 4'd9; bR = 4'd0; opR = 4'h5;
    @(posedge clk);
    #1;
    got = {resR, cR, zR, vR, nR};
    checks++;
    if (got !== {4'd6, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL after_reset_capture got=%b expected=%b", got, {4'd6, 4'b0000});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    a4 = '0; b4 = '0; op4 = '0;
    a8 = '0; b8 = '0; op8 = '0;
    aR = '0; bR = '0; opR = '0;
    $display("[TB] starting alu bench");
    test_shifts();
    test_arith();
    test_logic();
    test_unused();
    test_random();
    test_reset();
    test_registered();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
